flt_add_seq: RTL and testbench
==============================

FLT_ADD_SEQ -- requirements
Module: flt_add_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa width, excluding the hidden bit; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to begin an operation.
REQ-006 SHALL have port sub, input, 1, 0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have port op_a, input, W, operand A: {sign, exp, man}; sampled with start.
REQ-008 SHALL have port op_b, input, W, operand B; sampled with start.
REQ-009 SHALL have port result, output, W, sum or difference; held until the next accepted start.
REQ-010 SHALL have port busy, output, 1, high from the cycle after an accepted start through the DONE cycle.
REQ-011 SHALL have port done, output, 1, single-cycle pulse marking result valid.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, ROUND, DONE; DONE SHALL return to IDLE on the next cycle.
REQ-013 SHALL accept start only in IDLE, capturing op_a, op_b and sub; start in any other state is ignored.
REQ-014 SHALL treat exp==0 as zero, whatever the mantissa; there are no subnormals, and the hidden bit is !zero.
REQ-015 SHALL compute the effective operation as subtract when sign_a^sign_b^sub = 1, otherwise add.
REQ-016 ALIGN SHALL right-shift the smaller-exponent mantissa 1 bit per cycle, maintaining guard, round and sticky bits (sticky ORs all bits shifted past round).
REQ-017 ALIGN SHALL perform min(d, MAN_W+3) shifts, where d = |exp_a-exp_b|; d==0 spends exactly 1 ALIGN cycle.
REQ-018 ADD SHALL take 1 cycle, with MAN_W+2-bit magnitude arithmetic plus GRS; for subtract, the larger magnitude minus the smaller, and the result sign is that of the larger.
REQ-019 SHALL return +0 (all zeros) when the magnitudes are exactly equal under subtract.
REQ-020 On carry-out, NORM SHALL right-shift by 1 and increment the exponent in 1 cycle.
REQ-021 Otherwise, NORM SHALL left-shift 1 bit per cycle, shifting guard in and decrementing the exponent, until the hidden bit is set; a normalised result spends 1 NORM cycle.
REQ-022 If the exponent would reach 0 during NORM, result SHALL flush to signed zero.
REQ-023 ROUND SHALL round to nearest, ties to even, in 1 cycle; a mantissa carry from rounding SHALL increment the exponent.
REQ-024 If the final exponent reaches all-ones, result SHALL be signed infinity: exp all-ones, man 0.
REQ-025 Special inputs:
- either operand with exp all-ones SHALL yield that operand (op_a if both) with the normal latency;
- one zero operand SHALL yield the other operand, negated if it is b and sub=1;
- two zeros SHALL yield +0.
REQ-026 Total latency from the start edge to done SHALL be 4 + ALIGN cycles + NORM cycles.
REQ-027 result SHALL update in the cycle done asserts and SHALL not change otherwise.

Reset
REQ-028 While reset is high, SHALL force: state IDLE; result 0; done 0; busy 0; internal registers 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation; no done pulse follows.
REQ-030 After release, the first start SHALL be accepted on the first rising edge.

Verification
REQ-031 SHALL cover: 0x3C00 + 0x3C00, sub=0 -> result 0x4000, done after 6 cycles.
REQ-032 SHALL cover: 0x3E00 + 0x4100 (1.5+2.5) -> 0x4400.
REQ-033 SHALL cover: 0x3C00 - 0x3C00 (sub=1) -> 0x0000; and 0x3C00 + 0xBC00 -> 0x0000.
REQ-034 SHALL cover rounding:
- 0x3C01 + 0x1000 -> 0x3C02 (tie, round up to even);
- 0x3C00 + 0x1000 -> 0x3C00 (tie, stay even).
REQ-035 SHALL cover: 0x7BFF + 0x7BFF -> 0x7C00 (overflow to infinity).
REQ-036 SHALL cover: reset pulse during ALIGN of 0x3C00 + 0x1000 -> busy, done and result 0 immediately, with no done afterwards; a new start of 0x3C00 + 0x3C00 then -> 0x4000; start while busy is ignored.

Source files
------------

// File: rtl/flt_add_seq.sv
// Multi-cycle floating-point adder/subtractor: one bit of alignment or normalisation per clock,
// round-to-nearest-even, no subnormals (exp==0 is zero), exp all-ones is infinity.
//
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// ALIGN | right-shift the smaller mantissa one bit per cycle
// ADD   | magnitude add or subtract, larger minus smaller
// NORM  | one right shift on carry, else left shifts until the hidden bit is set
// ROUND | round to nearest even, then pack the result word
// DONE  | result valid for one cycle
module flt_add_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 busy,
  output logic                 done
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int FW     = MAN_W + 5;  // carry, hidden, fraction, guard, round, sticky
  localparam int SW     = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int MAX_SH = MAN_W + 3;
  localparam int CW     = $clog2(MAX_SH + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state;
  logic             sign_r;
  logic [EXP_W:0]   exp_r;
  logic [MAN_W:0]   big_m;
  logic [SW-1:0]    small_m;
  logic [FW-1:0]    acc;
  logic             eff_sub;
  logic [CW-1:0]    cnt;
  logic             special;
  logic [W-1:0]     spec_val;
  logic             zero_res;

  logic             a_sign, b_sign, b_sign_eff;
  logic [EXP_W-1:0] a_exp, b_exp, exp_diff;
  logic [MAN_W:0]   a_mant, b_mant;
  logic             a_zero, b_zero, a_inf, b_inf, a_ge;
  logic [CW-1:0]    shift_n;
  logic [W-1:0]     spec_in;

  logic [FW-1:0]    big_ext, small_ext, sum_w;
  logic             rup;
  logic [MAN_W:0]   frac_rnd;
  logic [EXP_W:0]   exp_fin;
  logic [W-1:0]     final_val;

  assign a_sign     = op_a[W-1];
  assign b_sign     = op_b[W-1];
  assign b_sign_eff = b_sign ^ sub;
  assign a_exp      = op_a[W-2:MAN_W];
  assign b_exp      = op_b[W-2:MAN_W];
  assign a_zero     = (a_exp == '0);
  assign b_zero     = (b_exp == '0);
  assign a_inf      = (a_exp == EXP_ONES);
  assign b_inf      = (b_exp == EXP_ONES);
  assign a_mant     = {~a_zero, op_a[MAN_W-1:0]};
  assign b_mant     = {~b_zero, op_b[MAN_W-1:0]};
  assign a_ge       = (op_a[W-2:0] >= op_b[W-2:0]);
  assign exp_diff   = a_ge ? (a_exp - b_exp) : (b_exp - a_exp);

  // Beyond MAX_SH shifts every bit already sits in sticky, so further shifts change nothing.
  always_comb begin
    if (int'(exp_diff) > MAX_SH) shift_n = CW'(MAX_SH);
    else                         shift_n = CW'(exp_diff);
  end

  always_comb begin
    spec_in = op_a;
    if (a_inf)                 spec_in = op_a;
    else if (b_inf)            spec_in = op_b;
    else if (a_zero && b_zero) spec_in = '0;
    else if (a_zero)           spec_in = {b_sign_eff, op_b[W-2:0]};
    else                       spec_in = op_a;
  end

  assign big_ext   = {1'b0, big_m, 3'b000};
  assign small_ext = {1'b0, small_m};
  assign sum_w     = eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);

  // Ties go up only when the kept LSB is odd.
  assign rup      = acc[2] & (acc[1] | acc[0] | acc[3]);
  assign frac_rnd = {1'b0, acc[MAN_W+2:3]} + {{MAN_W{1'b0}}, rup};
  assign exp_fin  = exp_r + {{EXP_W{1'b0}}, frac_rnd[MAN_W]};

  always_comb begin
    if (special)                         final_val = spec_val;
    else if (zero_res)                   final_val = {sign_r, {(W-1){1'b0}}};
    else if (exp_fin >= {1'b0, EXP_ONES}) final_val = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
    else                                 final_val = {sign_r, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      big_m    <= '0;
      small_m  <= '0;
      acc      <= '0;
      eff_sub  <= 1'b0;
      cnt      <= '0;
      special  <= 1'b0;
      spec_val <= '0;
      zero_res <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            eff_sub  <= a_sign ^ b_sign ^ sub;
            special  <= a_zero | b_zero | a_inf | b_inf;
            spec_val <= spec_in;
            zero_res <= 1'b0;
            cnt      <= (a_zero | b_zero | a_inf | b_inf) ? '0 : shift_n;
            if (a_ge) begin
              sign_r  <= a_sign;
              exp_r   <= {1'b0, a_exp};
              big_m   <= a_mant;
              small_m <= {b_mant, 3'b000};
            end else begin
              sign_r  <= b_sign_eff;
              exp_r   <= {1'b0, b_exp};
              big_m   <= b_mant;
              small_m <= {a_mant, 3'b000};
            end
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (cnt != '0) begin
            small_m <= {1'b0, small_m[SW-1:2], small_m[1] | small_m[0]};
            cnt     <= cnt - 1'b1;
          end
          if (cnt == '0 || cnt == CW'(1)) state <= S_ADD;
        end
        S_ADD: begin
          acc <= sum_w;
          if (sum_w == '0) begin
            zero_res <= 1'b1;
            sign_r   <= 1'b0;
          end
          state <= S_NORM;
        end
        S_NORM: begin
          if (special || zero_res) begin
            state <= S_ROUND;
          end else if (acc[FW-1]) begin
            acc   <= {1'b0, acc[FW-1:2], acc[1] | acc[0]};
            exp_r <= exp_r + 1'b1;
            state <= S_ROUND;
          end else if (acc[FW-2]) begin
            state <= S_ROUND;
          end else if (exp_r == (EXP_W+1)'(1)) begin
            zero_res <= 1'b1;
            state    <= S_ROUND;
          end else begin
            acc   <= {acc[FW-2:0], 1'b0};
            exp_r <= exp_r - 1'b1;
            if (acc[FW-3]) state <= S_ROUND;
          end
        end
        S_ROUND: begin
          result <= final_val;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flt_add_seq.sv
// Bench for flt_add_seq (half precision): vector table with hand-derived results and latencies,
// a scoreboard queue checked on every done pulse, and a reset-abort sequence.
module tb_flt_add_seq;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    int          lat;   // 0: latency not checked
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          start_cyc;
    int          id;
  } exp_t;

  localparam int NV = 21;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] result;
  logic        busy;
  logic        done;

  int   total;
  int   bad;
  int   cyc;
  int   n_done;
  int   nd0;
  vec_t vecs[NV];
  exp_t sb[$];

  flt_add_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=done result=%0h required=no done", result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_result", e.id), result, e.res);
        chk($sformatf("op%0d_busy_at_done", e.id), busy, 1);
        if (e.lat != 0)
          chk($sformatf("op%0d_latency", e.id), cyc - e.start_cyc + 1, e.lat);
      end
    end
  end

  task automatic run_vec(input int i);
    exp_t e;
    int   target;
    target = n_done + 1;
    @(negedge clk);
    e.res = vecs[i].res; e.lat = vecs[i].lat; e.start_cyc = cyc; e.id = i;
    sb.push_back(e);
    op_a = vecs[i].a; op_b = vecs[i].b; sub = vecs[i].sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && n_done < target; k++) @(negedge clk);
    if (n_done < target) begin
      total++;
      bad++;
      $display("FAIL op%0d_timeout actual=no done required=done", i);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    exp_t e;
    total = 0; bad = 0; n_done = 0;
    vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 6};
    vecs[1]  = '{16'h3E00, 16'h4100, 1'b0, 16'h4400, 6};
    vecs[2]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 6};
    vecs[3]  = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 6};
    vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 16};
    vecs[5]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 16};
    vecs[6]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 6};
    vecs[7]  = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 6};
    vecs[8]  = '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 6};
    vecs[9]  = '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 15};
    vecs[10] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 6};
    vecs[11] = '{16'h0400, 16'h0401, 1'b1, 16'h8000, 6};
    vecs[12] = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 18};
    vecs[13] = '{16'h3C00, 16'h1000, 1'b1, 16'h3BFF, 16};
    vecs[14] = '{16'h3FFF, 16'h1000, 1'b0, 16'h4000, 16};
    vecs[15] = '{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 0};
    vecs[16] = '{16'h3C00, 16'h0000, 1'b1, 16'h3C00, 0};
    vecs[17] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 0};
    vecs[18] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 0};
    vecs[19] = '{16'h3C00, 16'hFC00, 1'b1, 16'hFC00, 0};
    vecs[20] = '{16'h7C00, 16'hFC00, 1'b0, 16'h7C00, 0};

    reset = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Abort 0x3C00 + 0x1000 during its long ALIGN phase.
    @(negedge clk);
    op_a = 16'h3C00; op_b = 16'h1000; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    nd0 = n_done;

    @(negedge clk);
    reset = 1'b0;
    e.res = 16'h4000; e.lat = 6; e.start_cyc = cyc; e.id = 100;
    sb.push_back(e);
    op_a = 16'h3C00; op_b = 16'h3C00; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 16'h7BFF; op_b = 16'h7BFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("after_abort_done_count", n_done, nd0 + 1);
    chk("after_abort_result_held", result, 16'h4000);
    chk("after_abort_idle", busy, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
